imem_loader: RTL
================

# imem_loader

Boot-time instruction-memory writer for the 5-stage MIPS core. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into the instruction memory's word array, which the fetch stage reads through `PC[8:2]`. It holds the CPU off with `cpu_hold` until a complete, checksum-verified program has been loaded. It sits beside `Instruction_Mem`, on the write side of the interface that fetch reads.

## Interface
- `ADDR_W`, 7, word-address width; matches the IM index `PC[8:2]`.
- `DEPTH`, 128, number of IM words; a program length greater than DEPTH is an error.

Ports:
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high; highest priority.
- `start` in 1: one-cycle request to begin, or restart, a load session.
- `byte_valid` in 1: stream byte present.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: the loader accepts a byte this cycle.
- `im_we` out 1: IM write strobe, one cycle per word.
- `im_addr` out ADDR_W: IM word index.
- `im_wdata` out 32: instruction word.
- `cpu_hold` out 1: keep the pipeline stalled and PC at 0.
- `done` out 1: load completed with a good checksum.
- `error` out 1: the session failed.

## Operation
- Stream format: `LEN_HI`, `LEN_LO` (N words, 16-bit big-endian), then 4·N payload bytes (each word MSB first), then `CSUM`.
- `CSUM` is the XOR of all 4·N payload bytes. Header bytes are not included.
- States:
  - `IDLE`: waiting for `start`.
  - `HDR_HI`, `HDR_LO`: receiving the length header.
  - `DATA`: receiving payload bytes.
  - `CHK`: receiving the checksum byte.
  - `DONE`: load succeeded.
  - `ERR`: load failed.
- A handshake occurs when `byte_valid && byte_ready` at a rising edge.
- `byte_ready` is 1 exactly in `HDR_HI`, `HDR_LO`, `DATA` and `CHK`, and depends only on state.
- Transitions:
  - `IDLE`, `DONE` or `ERR` with `start` → `HDR_HI`.
  - `HDR_HI`, on handshake → `HDR_LO`.
  - `HDR_LO`, on handshake: if N==0 or N>DEPTH → `ERR`; otherwise → `DATA`.
  - `DATA`: a 2-bit byte counter and a word counter (ADDR_W+1 bits) advance on each handshake. After the 4th byte of word N−1 → `CHK`.
  - `CHK`, on handshake: byte == running XOR → `DONE`; otherwise → `ERR`.
- `start` in any non-`IDLE` state aborts the session and goes to `HDR_HI`. It clears the counters, the XOR accumulator, `done` and `error`. A byte handshaked in the same cycle as `start` is discarded.
- Words already written before an abort or error stay in the IM. There is no rollback.
- Outputs by state:
  - `cpu_hold` = 0 only in `DONE`; it is 1 in every other state, including `IDLE` after reset.
  - `done` = 1 only in `DONE`.
  - `error` = 1 only in `ERR`.
- Word addresses run from 0 to N−1 with no wrap. When N = DEPTH, the last address is DEPTH−1.

## Timing
- Reset values: state `IDLE`, `byte_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0. Counters and the XOR accumulator are 0.
- All outputs are registered.
- Write latency: for the 4th byte of word k handshaked at edge t, the following hold during cycle t+1:
  - `im_we`=1 for exactly one cycle,
  - `im_addr`=k,
  - `im_wdata` = the assembled word.
- The IM latches the write at edge t+1.
- Full throughput is supported: one byte per cycle and one `im_we` pulse every 4 cycles, with no back-pressure inside a session.
- Transitions on the `CHK` handshake at edge t:
  - `done`=1 and `cpu_hold`=0 from cycle t+1.
  - `byte_ready`=0 from cycle t+1.
- A write strobe pending at `RST` or `start` is cancelled: `im_we`=0 in the next cycle.
- Minimum session length is 2 + 4·N + 1 handshake cycles after the `start` cycle.

## Test plan
- Reset, then stream 00 01 12 34 56 78 12^34^56^78=08 at one byte per cycle:
  - exactly one `im_we` pulse, with `im_addr`=0 and `im_wdata`=0x12345678;
  - `done`=1 and `cpu_hold`=0 one cycle after the checksum handshake.
- N=3 with `byte_valid` toggled randomly:
  - writes to addresses 0, 1, 2 in order with the correct words;
  - no write while `byte_valid`=0 stalls a word;
  - `done` at the end.
- Header 00 00, and separately 00 81 (129 with DEPTH=128):
  - `ERR` after `LEN_LO`, `error`=1, `cpu_hold`=1, no `im_we`.
- Header 00 80 (N=128) with a wrong checksum:
  - 128 writes, the last at `im_addr`=127;
  - `error`=1, `done`=0, `cpu_hold` stays 1.
- `start` asserted mid-`DATA` after 5 bytes:
  - state restarts at `HDR_HI`;
  - a full new N=1 session writes at address 0 and reaches `DONE`;
  - the byte coinciding with `start` is not counted.
- `RST` asserted for one cycle during the cycle after a 4th-byte handshake:
  - `im_we`=0 and all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the MIPS instruction memory.
// Assembles big-endian words from a valid/ready byte stream, writes them to
// the IM word array, verifies an XOR checksum and releases cpu_hold on success.
module imem_loader #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned LEN_W     = 16;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        CHK,
        DONE,
        ERR
    } state_e;

    state_e             state, stateNext;
    logic [LEN_W-1:0]   lenWords, lenNext;
    logic [1:0]         byteCnt, byteCntNext;
    logic [CNT_W-1:0]   wordCnt, wordCntNext;
    logic [7:0]         xorAcc, xorNext;
    logic [23:0]        wordBuf, bufNext;
    logic               weNext;
    logic [ADDR_W-1:0]  addrNext;
    logic [31:0]        wdataNext;
    logic               readyNext, holdNext, doneNext, errorNext;
    logic               handshake;

    // Next-state, datapath and registered-output next values
    always_comb begin
        stateNext   = state;
        lenNext     = lenWords;
        byteCntNext = byteCnt;
        wordCntNext = wordCnt;
        xorNext     = xorAcc;
        bufNext     = wordBuf;
        weNext      = 1'b0;
        addrNext    = im_addr;
        wdataNext   = im_wdata;
        handshake   = byte_valid && byte_ready;

        if (start) begin
            // Restart from any state; a byte arriving with start is dropped.
            stateNext   = HDR_HI;
            lenNext     = '0;
            byteCntNext = '0;
            wordCntNext = '0;
            xorNext     = '0;
            bufNext     = '0;
        end else begin
            case (state)
                HDR_HI: begin
                    if (handshake) begin
                        lenNext   = {byte_data, 8'h00};
                        stateNext = HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (handshake) begin
                        lenNext = {lenWords[15:8], byte_data};
                        if (lenNext == '0 || lenNext > DEPTH_LEN) begin
                            stateNext = ERR;
                        end else begin
                            stateNext = DATA;
                        end
                    end
                end
                DATA: begin
                    if (handshake) begin
                        xorNext     = xorAcc ^ byte_data;
                        byteCntNext = byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            weNext      = 1'b1;
                            addrNext    = wordCnt[ADDR_W-1:0];
                            wdataNext   = {wordBuf, byte_data};
                            wordCntNext = wordCnt + CNT_W'(1);
                            if (LEN_W'(wordCnt) + LEN_W'(1) == lenWords) begin
                                stateNext = CHK;
                            end
                        end else begin
                            bufNext = {wordBuf[15:0], byte_data};
                        end
                    end
                end
                CHK: begin
                    if (handshake) begin
                        stateNext = (byte_data == xorAcc) ? DONE : ERR;
                    end
                end
                default: begin
                    stateNext = state;
                end
            endcase
        end

        readyNext = (stateNext == HDR_HI) || (stateNext == HDR_LO) ||
                    (stateNext == DATA)   || (stateNext == CHK);
        holdNext  = (stateNext != DONE);
        doneNext  = (stateNext == DONE);
        errorNext = (stateNext == ERR);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            lenWords   <= '0;
            byteCnt    <= '0;
            wordCnt    <= '0;
            xorAcc     <= '0;
            wordBuf    <= '0;
            byte_ready <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= stateNext;
            lenWords   <= lenNext;
            byteCnt    <= byteCntNext;
            wordCnt    <= wordCntNext;
            xorAcc     <= xorNext;
            wordBuf    <= bufNext;
            byte_ready <= readyNext;
            im_we      <= weNext;
            im_addr    <= addrNext;
            im_wdata   <= wdataNext;
            cpu_hold   <= holdNext;
            done       <= doneNext;
            error      <= errorNext;
        end
    end

endmodule
